// File: rtl/freq_meas_pkg.sv
// Shared types and helpers for the frequency-measurement sequencer.
//   state_t   : sequencer state encoding (also exported on the debug port)
//   NUM_W     : width of the numerator x_cnt*FSTD (27-bit count x 27-bit FSTD)
//   cnt_width : number of bits needed to hold a given cycle count
package freq_meas_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    PRE,
    GATE,
    SETTLE,
    LATCH,
    WAIT_REL,
    MUL,
    DIV,
    DONE
  } state_t;

  localparam int NUM_W = 54;

  // Bits required to represent max_val (at least 1).
  function automatic int cnt_width(input int unsigned max_val);
    int w;
    w = 1;
    for (int i = 0; i < 32; i++) begin
      if ((max_val >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/freq_meas_ctrl_if.sv
// Link between the sequencer and the cross-domain counter block.
//   gate      : measurement gate (sequencer -> counters)
//   clr_req   : counter clear request
//   latch_req : request to freeze and present counts
//   latch_ack : acknowledge from the counter domain (asynchronous)
//   x_cnt     : test-clock edge count, stable while latch_ack is high
//   y_cnt     : reference-clock edge count, stable while latch_ack is high
// Handshake: 4-phase req/ack. latch_req rises; the counter side freezes the
// counts and raises latch_ack; the sequencer samples the counts and drops
// latch_req; the counter side drops latch_ack, completing the cycle.
interface freq_meas_ctrl_if #(
  parameter int CNT_W = 27
);
  logic             gate;
  logic             clr_req;
  logic             latch_req;
  logic             latch_ack;
  logic [CNT_W-1:0] x_cnt;
  logic [CNT_W-1:0] y_cnt;

  modport master (
    output gate, clr_req, latch_req,
    input  latch_ack, x_cnt, y_cnt
  );

  modport slave (
    input  gate, clr_req, latch_req,
    output latch_ack, x_cnt, y_cnt
  );
endinterface

// File: rtl/freq_meas_ctrl_seq_divider.sv
// Restoring divider, one quotient bit per clock.
//   load : latch num/den and start (one cycle)
//   num  : N_W-bit dividend
//   den  : D_W-bit divisor (0 yields an all-ones quotient, never used)
//   quo  : low Q_W bits of the quotient, final while done is high
//   done : one-cycle pulse exactly N_W cycles after load
module seq_divider
  import freq_meas_pkg::*;
#(
  parameter int N_W = NUM_W,
  parameter int D_W = 27,
  parameter int Q_W = 50
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [N_W-1:0] num,
  input  logic [D_W-1:0] den,
  output logic [Q_W-1:0] quo,
  output logic           done
);
  localparam int BW = $clog2(N_W + 1);

  logic [N_W-1:0] q_q;
  logic [D_W:0]   rem_q;
  logic [D_W-1:0] den_q;
  logic [BW-1:0]  bits_q;
  logic           run_q;
  logic [D_W+1:0] part;
  logic [D_W+1:0] diff;
  logic           take;

  // Partial remainder stays below den, so part < 2^(D_W+1) and the sign
  // bit of the extended subtraction is a clean borrow flag.
  always_comb begin
    part = {rem_q, q_q[N_W-1]};
    diff = part - {2'b00, den_q};
    take = ~diff[D_W+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      bits_q <= '0;
      run_q  <= 1'b0;
    end else if (load) begin
      q_q    <= num;
      rem_q  <= '0;
      den_q  <= den;
      bits_q <= BW'(N_W);
      run_q  <= 1'b1;
    end else if (run_q) begin
      if (bits_q != '0) begin
        q_q    <= {q_q[N_W-2:0], take};
        rem_q  <= take ? diff[D_W:0] : part[D_W:0];
        bits_q <= bits_q - BW'(1);
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign done = run_q && (bits_q == '0);
  assign quo  = q_q[Q_W-1:0];
endmodule

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer for the reciprocal frequency counter.
// Runs clear -> pre-delay -> gate -> settle -> latch handshake, then
// computes freq_data = x_cnt*FSTD/y_cnt with a bit-serial divider.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   start, cont_mode   : one-shot trigger / automatic re-arm level
//   abort              : cancel the run in progress (wins over start)
//   cnt_bus            : gate/clear/latch handshake to the counter block
//   freq_data/valid    : last result and its one-cycle update strobe
//   busy, err_zero, err_timeout : status; err flags clear on each new run
//   dbg_state          : current sequencer state
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int          CNT_W       = 27,
  parameter int          DATA_W      = 50,
  parameter int unsigned FSTD        = 100_000_000,
  parameter int unsigned PRE_CYC     = 12_500_000,
  parameter int unsigned GATE_CYC    = 50_000_000,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned CLR_CYC     = 8,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic                  cont_mode,
  input  logic                  abort,
  freq_meas_ctrl_if.master      cnt_bus,
  output logic [DATA_W-1:0]     freq_data,
  output logic                  freq_valid,
  output logic                  busy,
  output logic                  err_zero,
  output logic                  err_timeout,
  output state_t                dbg_state
);
  localparam int unsigned MAX_A   = (PRE_CYC > GATE_CYC) ? PRE_CYC : GATE_CYC;
  localparam int unsigned MAX_B   = (SETTLE_CYC > CLR_CYC) ? SETTLE_CYC : CLR_CYC;
  localparam int unsigned MAX_C   = (MAX_B > ACK_TIMEOUT) ? MAX_B : ACK_TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int          CW      = cnt_width(MAX_CYC);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, reload;
  logic               cnt_zero;
  logic               ack_m, ack_s;
  logic               tmo_q;
  logic [CNT_W-1:0]   x_q, y_q;
  logic               gate_q, clr_q, latch_q;
  logic               ev_arm, ev_ack, ev_tmo, ev_zero;
  logic               div_load, div_done;
  logic [NUM_W-1:0]   num;
  logic [DATA_W-1:0]  div_quo;

  assign cnt_zero = (cnt_q == '0);
  assign num      = NUM_W'(x_q) * NUM_W'(FSTD);
  assign div_load = (state_q == WAIT_REL) && (state_d == MUL);

  // Next state and one-cycle events. Abort pre-empts everything outside IDLE.
  always_comb begin
    state_d = state_q;
    ev_arm  = 1'b0;
    ev_ack  = 1'b0;
    ev_tmo  = 1'b0;
    ev_zero = 1'b0;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if ((start || cont_mode) && !abort) begin
                    state_d = CLEAR;
                    ev_arm  = 1'b1;
                  end
        CLEAR:    if (cnt_zero) state_d = PRE;
        PRE:      if (cnt_zero) state_d = GATE;
        GATE:     if (cnt_zero) state_d = SETTLE;
        SETTLE:   if (cnt_zero) state_d = LATCH;
        LATCH:    if (ack_s) begin
                    state_d = WAIT_REL;
                    ev_ack  = 1'b1;
                  end else if (cnt_zero) begin
                    state_d = WAIT_REL;
                    ev_tmo  = 1'b1;
                  end
        WAIT_REL: if (!ack_s) state_d = tmo_q ? IDLE : MUL;
        MUL:      if (y_q == '0) begin
                    state_d = IDLE;
                    ev_zero = 1'b1;
                  end else begin
                    state_d = DIV;
                  end
        DIV:      if (div_done) state_d = DONE;
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Dwell counter preset for the state being entered; a state lasting N
  // cycles leaves when the counter has run down from N-1 to zero.
  always_comb begin
    reload = '0;
    case (state_d)
      CLEAR:   reload = CW'(CLR_CYC - 1);
      PRE:     reload = CW'(PRE_CYC - 1);
      GATE:    reload = CW'(GATE_CYC - 1);
      SETTLE:  reload = CW'(SETTLE_CYC - 1);
      LATCH:   reload = CW'(ACK_TIMEOUT - 1);
      default: reload = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_m       <= 1'b0;
      ack_s       <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      gate_q      <= 1'b0;
      clr_q       <= 1'b0;
      latch_q     <= 1'b0;
      busy        <= 1'b0;
      freq_valid  <= 1'b0;
      freq_data   <= '0;
      err_zero    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ack_m   <= cnt_bus.latch_ack;
      ack_s   <= ack_m;
      state_q <= state_d;
      if (state_d != state_q)   cnt_q <= reload;
      else if (!cnt_zero)       cnt_q <= cnt_q - CW'(1);

      // Outputs decoded from the next state so they switch on the same
      // edge as the state register and come straight out of flops.
      gate_q     <= (state_d == GATE);
      clr_q      <= (state_d == CLEAR);
      latch_q    <= (state_d == LATCH);
      busy       <= (state_d != IDLE);
      freq_valid <= (state_d == DONE);
      if (state_d == DONE) freq_data <= div_quo;

      if (ev_arm) begin
        err_zero    <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (ev_ack) begin
        x_q   <= cnt_bus.x_cnt;
        y_q   <= cnt_bus.y_cnt;
        tmo_q <= 1'b0;
      end
      if (ev_tmo) begin
        tmo_q       <= 1'b1;
        err_timeout <= 1'b1;
      end
      if (ev_zero) err_zero <= 1'b1;
    end
  end

  // Loaded on entry to MUL so the quotient is final after NUM_W DIV cycles.
  seq_divider #(
    .N_W (NUM_W),
    .D_W (CNT_W),
    .Q_W (DATA_W)
  ) u_div (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .load  (div_load),
    .num   (num),
    .den   (y_q),
    .quo   (div_quo),
    .done  (div_done)
  );

  assign cnt_bus.gate      = gate_q;
  assign cnt_bus.clr_req   = clr_q;
  assign cnt_bus.latch_req = latch_q;
  assign dbg_state         = state_q;
endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
- Sequencer for the reciprocal frequency-measurement datapath. Runs the measurement cycle: clear the counters, pre-delay, drive the gate, settle, latch the counts.
- Captures x_cnt (test-clock edges) and y_cnt (reference-clock edges) through a req/ack handshake, then computes freq_data = x_cnt*FSTD/y_cnt with a multi-cycle divider. This replaces a single-cycle combinational divide.
- Sits in the sys_clk domain between the top level and the cross-domain counter block.

Parameters:
- CNT_W, 27, width of x_cnt/y_cnt.
- DATA_W, 50, width of freq_data.
- FSTD, 100_000_000, reference clock frequency in Hz; must be < 2^27.
- PRE_CYC, 12_500_000, sys_clk cycles of gate-low pre-delay (250 ms at 50 MHz).
- GATE_CYC, 50_000_000, sys_clk cycles the gate is high (1 s at 50 MHz).
- SETTLE_CYC, 16, sys_clk cycles after gate fall before the latch request.
- CLR_CYC, 8, sys_clk cycles clr_req is held high.
- ACK_TIMEOUT, 1024, sys_clk cycles to wait for latch_ack.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin one measurement
- cont_mode  in  1  level: re-arm automatically after each result
- abort  in  1  one-cycle pulse: cancel the measurement in progress
- gate  out  1  measurement gate to the counter block
- clr_req  out  1  counter clear request
- latch_req  out  1  request to freeze and present counts
- latch_ack  in  1  asynchronous ack from the counter domain
- x_cnt  in  CNT_W  test-clock count; stable while latch_ack is high
- y_cnt  in  CNT_W  reference-clock count; stable while latch_ack is high
- freq_data  out  DATA_W  last valid frequency result, in Hz
- freq_valid  out  1  one-cycle pulse when freq_data is updated
- busy  out  1  high in every state except IDLE
- err_zero  out  1  sticky: last measurement had y_cnt == 0
- err_timeout  out  1  sticky: last latch handshake timed out

Behaviour:
- Reset (sys_rst_n, asynchronous, active-low; clock sys_clk): state IDLE. Outputs gate, clr_req, latch_req, freq_valid, busy, err_zero, err_timeout and freq_data all reset to 0. The latch_ack synchroniser flops reset to 0.
- latch_ack passes through a 2-FF synchroniser (ack_s). All decisions use ack_s.
- A single down-counter (wide enough for max(PRE_CYC, GATE_CYC)) is reloaded on every state entry.
- IDLE: on start=1, or cont_mode=1, go to CLEAR. On that transition err_zero and err_timeout are cleared.
- CLEAR: clr_req=1 for exactly CLR_CYC cycles, then go to PRE.
- PRE: gate=0 for PRE_CYC cycles, then go to GATE.
- GATE: gate=1 for exactly GATE_CYC cycles, then go to SETTLE. gate is driven from a register, glitch-free.
- SETTLE: wait SETTLE_CYC cycles, then go to LATCH.
- LATCH: latch_req=1.
  - When ack_s=1: register x_cnt and y_cnt, drop latch_req, go to WAIT_REL.
  - If ACK_TIMEOUT cycles pass without ack_s: set err_timeout, drop latch_req, go to WAIT_REL.
- WAIT_REL: wait for ack_s=0 (the 4-phase handshake completes).
  - If the timeout path was taken, go to IDLE; freq_data is unchanged and there is no freq_valid.
  - Otherwise go to MUL.
- MUL: one cycle. Register num = x_cnt*FSTD, width CNT_W+27 (NUM_W = 54).
  - If y_cnt == 0: set err_zero and go to IDLE; freq_data is unchanged.
  - Otherwise go to DIV.
- DIV: restoring divider, one quotient bit per cycle, exactly NUM_W cycles. The quotient is truncated to its low DATA_W bits (no saturation needed for legal inputs).
- DONE: one cycle. Load freq_data, freq_valid=1, go to IDLE.
- Latency from start to freq_valid = 1 (IDLE) + CLR_CYC + PRE_CYC + GATE_CYC + SETTLE_CYC + handshake (3 to 6 cycles, depending on synchroniser phase) + 1 (MUL) + NUM_W + 1.
- cont_mode=1 in IDLE re-arms on the next cycle. Clearing cont_mode mid-run finishes the current measurement and then stops.
- start while busy=1 is ignored. It is not queued.
- abort in any non-IDLE state: go to IDLE on the next edge; gate, clr_req and latch_req drop that same edge. freq_data and the err flags are unchanged. abort in IDLE has no effect.
- abort and start in the same cycle: abort wins.
- Reset mid-run: immediate IDLE, all outputs at reset values.

Decomposition:
- Package freq_meas_pkg holds:
  - state enum: IDLE, CLEAR, PRE, GATE, SETTLE, LATCH, WAIT_REL, MUL, DIV, DONE
  - NUM_W localparam
  - counter width function (clog2 helper)
- Sub-module seq_divider (NUM_W / CNT_W restoring divider):
  - inputs: load, num, den
  - outputs: quo, done
  - done is high exactly NUM_W cycles after load.
- Keep the synchroniser inline.

Test Plan:
- Common settings: PRE_CYC=4, GATE_CYC=100, SETTLE_CYC=4, CLR_CYC=2, FSTD=1000. The ack model responds 2 cycles after latch_req and presents x=50, y=100.
- Single run: start pulse -> clr_req high exactly 2 cycles, gate high exactly 100 cycles, freq_valid one pulse, freq_data = 500, busy low afterwards.
- Zero denominator: ack with x=7, y=0 -> err_zero=1, no freq_valid, freq_data keeps its previous value (500), busy drops.
- Timeout: ACK_TIMEOUT=16 and latch_ack never rises -> err_timeout=1 after 16 LATCH cycles, latch_req drops, no freq_valid.
- Continuous mode: cont_mode=1 with x=3, y=1 -> back-to-back freq_valid pulses each = 3000. Clearing cont_mode mid-gate gives exactly one more result.
- Abort: abort at gate cycle 50 -> gate low on the next edge, busy low, freq_data unchanged. A start in the same cycle as the abort is ignored.
- Reset mid-DIV: sys_rst_n low -> all outputs 0 immediately. A subsequent start completes normally with freq_data = 500.
